// File: rtl/video_pkg.sv
// Shared constants, pixel-format helpers and capture state type for the video paths.
package video_pkg;

    localparam logic [9:0]  H_ACT   = 10'd640;
    localparam logic [9:0]  V_ACT   = 10'd400;
    localparam int          DECIM   = 4;
    localparam logic [13:0] FB_W    = 14'd160;
    localparam logic [13:0] FB_SIZE = 14'd16000;

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} cap_state_t;

    function automatic logic [7:0] pack_rgb332(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

    // Bit replication so full-scale 332 values expand to full-scale 888 values.
    function automatic logic [23:0] unpack_rgb332(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    // Constant multiply as a sum of shifted copies; with k fixed this collapses to adders.
    function automatic logic [13:0] mul_const(input logic [13:0] v, input logic [13:0] k);
        logic [13:0] acc;
        acc = '0;
        for (int i = 0; i < 14; i++) begin
            if (k[i]) acc = acc + (v << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Input register stage for the VGA receiver with vsync rise and data-enable fall detection.
module vga_edge_sync
    import video_pkg::*;
(
    input  logic       pclk,
    input  logic       reset,
    input  logic       vs,
    input  logic       de,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       vs_rise,
    output logic       de_fall,
    output logic       de_q,
    output logic [7:0] pix_q
);

    logic vs_q;
    logic vs_d;
    logic de_d;

    always_ff @(posedge pclk) begin
        if (reset) begin
            vs_q  <= 1'b0;
            vs_d  <= 1'b0;
            de_q  <= 1'b0;
            de_d  <= 1'b0;
            pix_q <= '0;
        end else begin
            vs_q  <= vs;
            vs_d  <= vs_q;
            de_q  <= de;
            de_d  <= de_q;
            pix_q <= pack_rgb332(r, g, b);
        end
    end

    assign vs_rise = vs_q & ~vs_d;
    assign de_fall = de_d & ~de_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: decimates the active area to an RGB332 frame buffer and checks frame geometry.
module vga_capture #(
    parameter logic [9:0]  H_ACT = video_pkg::H_ACT,
    parameter logic [9:0]  V_ACT = video_pkg::V_ACT,
    parameter int          DECIM = video_pkg::DECIM,
    parameter logic [13:0] FB_W  = video_pkg::FB_W
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        capture_en,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic        locked
);

    import video_pkg::*;

    localparam int DS = $clog2(DECIM);

    logic       vs_rise;
    logic       de_fall;
    logic       de_q;
    logic [7:0] pix_q;

    cap_state_t  state;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        err;
    logic [13:0] xb;
    logic [13:0] yb;
    logic [13:0] addr;
    logic        unused_hs;

    assign unused_hs = hs;

    vga_edge_sync u_edge (
        .pclk    (pclk),
        .reset   (reset),
        .vs      (vs),
        .de      (de),
        .r       (r),
        .g       (g),
        .b       (b),
        .vs_rise (vs_rise),
        .de_fall (de_fall),
        .de_q    (de_q),
        .pix_q   (pix_q)
    );

    assign xb   = 14'(x >> DS);
    assign yb   = 14'(y >> DS);
    assign addr = mul_const(yb, FB_W) + xb;

    // A vs_rise closes the frame even if de is high in the same cycle; that pixel is dropped
    // and marks the closing frame bad.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            err        <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture_en) state <= SYNC;
                end
                SYNC: begin
                    if (vs_rise) begin
                        state <= ACTIVE;
                        x     <= '0;
                        y     <= '0;
                        err   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        if (y == V_ACT && !err && !de_q) begin
                            frame_done <= 1'b1;
                            locked     <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                        end
                        x     <= '0;
                        y     <= '0;
                        err   <= 1'b0;
                        state <= capture_en ? ACTIVE : IDLE;
                    end else if (de_q) begin
                        if (x != '1) x <= x + 10'd1;
                        if (x < H_ACT && y < V_ACT) begin
                            if (x[DS-1:0] == '0 && y[DS-1:0] == '0) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= pix_q;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (de_fall) begin
                        if (x != H_ACT) err <= 1'b1;
                        x <= '0;
                        if (y != '1) y <= y + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced 16x8 active geometry (4x2 byte buffer).
module tb_vga_capture;

    localparam int H      = 16;
    localparam int V      = 8;
    localparam int FBW    = 4;
    localparam int HBLANK = 8;

    logic        pclk = 1'b0;
    logic        reset;
    logic        hs;
    logic        vs;
    logic        de;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        capture_en;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic        frame_err;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int wq_addr[$];
    int wq_data[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [25:0] rst_snap;

    vga_capture #(
        .H_ACT (10'd16),
        .V_ACT (10'd8),
        .DECIM (4),
        .FB_W  (14'd4)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .r          (r),
        .g          (g),
        .b          (b),
        .capture_en (capture_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    always #5 pclk = ~pclk;

    // Record writes and status pulses on the falling edge, away from the capturing edge.
    always @(negedge pclk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source pixel at (x,y) uses r = x*16, g = y*32, b = 0xC0.
    function automatic int expData(input int a);
        int col;
        int row;
        logic [7:0] rr;
        logic [7:0] gg;
        col = a % FBW;
        row = a / FBW;
        rr  = 8'(col * 4 * 16);
        gg  = 8'(row * 4 * 32);
        return int'({rr[7:5], gg[7:5], 2'b11});
    endfunction

    task automatic applyStimulus(input int lines, input int short_line, input int short_len,
                                 input int en_line, input int rst_line, input bit vs_on_de);
        int len;
        for (int l = 0; l < lines; l++) begin
            if (l == en_line) capture_en = 1'b1;
            if (l == rst_line) begin
                reset = 1'b1;
                de    = 1'b0;
                @(negedge pclk);
                reset    = 1'b0;
                rst_snap = {wr_en, frame_done, frame_err, locked, wr_addr, wr_data};
            end
            len = (l == short_line) ? short_len : H;
            for (int c = 0; c < len; c++) begin
                de = 1'b1;
                r  = 8'(c * 16);
                g  = 8'(l * 32);
                b  = 8'hC0;
                @(negedge pclk);
            end
            de = 1'b0;
            for (int c = 0; c < HBLANK; c++) begin
                hs = !(c >= 2 && c < 5);
                @(negedge pclk);
            end
        end
        hs = 1'b1;
        repeat (4) @(negedge pclk);
        vs = 1'b1;
        de = vs_on_de;
        @(negedge pclk);
        de = 1'b0;
        repeat (2) @(negedge pclk);
        vs = 1'b0;
        repeat (6) @(negedge pclk);
    endtask

    task automatic checkOutput(input string tag, input int exp_writes, input int exp_done,
                               input int exp_err, input logic exp_locked);
        chk({tag, " writes"}, wq_addr.size(), exp_writes);
        for (int i = 0; i < wq_addr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wq_addr[i], i);
            chk($sformatf("%s data[%0d]", tag, i), wq_data[i], expData(i));
        end
        chk({tag, " frame_done"}, done_cnt, exp_done);
        chk({tag, " frame_err"}, err_cnt, exp_err);
        chk({tag, " locked"}, {31'b0, locked}, {31'b0, exp_locked});
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    initial begin
        reset      = 1'b1;
        hs         = 1'b1;
        vs         = 1'b0;
        de         = 1'b0;
        r          = '0;
        g          = '0;
        b          = '0;
        capture_en = 1'b0;
        rst_snap   = '1;
        repeat (3) @(negedge pclk);
        chk("reset wr_en", {31'b0, wr_en}, 0);
        chk("reset wr_addr", {18'b0, wr_addr}, 0);
        chk("reset wr_data", {24'b0, wr_data}, 0);
        chk("reset frame_done", {31'b0, frame_done}, 0);
        chk("reset frame_err", {31'b0, frame_err}, 0);
        chk("reset locked", {31'b0, locked}, 0);
        reset = 1'b0;
        @(negedge pclk);
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
        both_cnt = 0;

        applyStimulus(V, -1, 0, -1, -1, 1'b0);
        checkOutput("disabled", 0, 0, 0, 1'b0);

        applyStimulus(V, -1, 0, 3, -1, 1'b0);
        checkOutput("en_midframe", 0, 0, 0, 1'b0);

        applyStimulus(V, -1, 0, -1, -1, 1'b0);
        chk("pixel(4,4) data", (wq_data.size() > 5) ? wq_data[5] : -1, 32'h53);
        checkOutput("clean1", 8, 1, 0, 1'b1);

        applyStimulus(V, 3, 12, -1, -1, 1'b0);
        checkOutput("short_line", 8, 0, 1, 1'b0);

        applyStimulus(V, -1, 0, -1, -1, 1'b0);
        checkOutput("clean2", 8, 1, 0, 1'b1);

        applyStimulus(V + 4, -1, 0, -1, -1, 1'b0);
        checkOutput("extra_lines", 8, 0, 1, 1'b0);

        applyStimulus(V, -1, 0, -1, -1, 1'b0);
        checkOutput("clean3", 8, 1, 0, 1'b1);

        applyStimulus(V, -1, 0, -1, 2, 1'b0);
        chk("reset_mid outputs", {6'b0, rst_snap}, 0);
        checkOutput("reset_mid", 4, 0, 0, 1'b0);

        applyStimulus(V, -1, 0, -1, -1, 1'b0);
        checkOutput("clean4", 8, 1, 0, 1'b1);

        applyStimulus(V, -1, 0, -1, -1, 1'b1);
        checkOutput("vs_on_de", 8, 0, 1, 1'b0);

        chk("done_and_err_together", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receiving end of the 640x400@70Hz VGA stream produced by the video output path: samples hs/vs/de/RGB888 on the pixel clock.
- Decimates each 4x4 pixel block to one sample (top-left pixel) and packs it to RGB332.
- Emits write strobes into a 160x100, 8-bit frame buffer (16000 bytes, linear address = row*160 + col).
- Checks frame geometry and reports lock and error status, for loop-back testing of the video output and for overlay grab features.

Parameters:
- H_ACT, 640, active pixels per line expected.
- V_ACT, 400, active lines per frame expected.
- DECIM, 4, decimation factor in both axes (power of two; only 4 is verified).
- FB_W, 160, frame buffer width in bytes (H_ACT/DECIM).

Ports:
- pclk  input  1  pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- hs  input  1  hsync, active low (used only for monitoring; not required for capture).
- vs  input  1  vsync, active high.
- de  input  1  data enable, high in the active area.
- r  input  8  red.
- g  input  8  green.
- b  input  8  blue.
- capture_en  input  1  enable continuous frame capture.
- wr_en  output  1  frame buffer write strobe.
- wr_addr  output  14  frame buffer byte address, 0..15999.
- wr_data  output  8  RGB332 pixel: {r[7:5], g[7:5], b[7:6]}.
- frame_done  output  1  one-cycle pulse: frame captured with correct geometry.
- frame_err  output  1  one-cycle pulse: frame ended with a geometry error.
- locked  output  1  last completed frame was correct.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Takes effect on the next pclk edge, including mid-frame. A partially written frame is abandoned and no status pulse is issued.
- Input stage: vs, de and r/g/b registered once. vs_rise = registered vs high and previous low. de_fall detected the same way.
- States:
  - IDLE: no writes. capture_en=1 -> SYNC.
  - SYNC: wait for vs_rise -> ACTIVE, and clear x, y and err.
  - ACTIVE: capture. On vs_rise, evaluate the frame (see below), clear x, y and err, then stay in ACTIVE if capture_en=1, else go to IDLE.
  - capture_en deassert mid-frame has no effect until the next vs_rise.
- Counters:
  - x (10b) increments on each registered de=1 cycle.
  - On de_fall: if x != H_ACT, set err. Then x <= 0 and y <= y+1 (10b).
- Write condition (registered de=1):
  - x < H_ACT, y < V_ACT, x[1:0]==0 and y[1:0]==0.
  - wr_addr = (y>>2)*160 + (x>>2), computed as (yb<<7)+(yb<<5)+xb; no multiplier.
  - wr_data is the packed pixel.
- Latency: wr_en/wr_addr/wr_data are registered and valid 2 pclk after the pixel is present on the input pins. wr_en is high for exactly one cycle per written byte; wr_addr and wr_data are don't-care when wr_en=0.
- Overrun: x >= H_ACT or y >= V_ACT while de=1 -> no write, set err.
- Frame evaluation at vs_rise:
  - If y == V_ACT and err=0: frame_done pulse and locked <= 1.
  - Otherwise: frame_err pulse and locked <= 0.
  - frame_done and frame_err are never high together.
- Simultaneous vs_rise and registered de=1: vs takes precedence. That pixel is not written and counts as an error for the frame being closed.
- The first vs_rise after SYNC only starts capture; it produces no status pulse.
- A correct frame produces exactly 16000 writes covering addresses 0..15999, each once, in ascending order.

Decomposition:
- Shared package `video_pkg`:
  - Constants H_ACT, V_ACT, FB_W, FB_SIZE=16000.
  - RGB332 pack/unpack functions, shared with the output path's 332->888 expansion.
  - State enum {IDLE, SYNC, ACTIVE}.
- One natural sub-module, `vga_edge_sync`: input register plus vs_rise/de_fall detection.
- Counters, address generation and the FSM stay in `vga_capture`.

Test Plan:
- Clean frames: capture_en=1; drive two 640x400 frames with standard 800x449 timing, pixel colour r=x, g=y[7:0], b=0xC0 -> second frame gives 16000 writes, addr 0..15999 ascending. Write at addr 161 carries pixel (4,4): data = {3'b000, 3'b000, 2'b11} = 0x03. Then one frame_done pulse, locked=1.
- Short line: line 10 has 636 de cycles -> frame_err pulse at vs_rise, locked=0. The following clean frame gives frame_done and locked=1.
- Extra lines: 404 active lines -> no write beyond addr 15999, frame_err pulse, locked=0.
- capture_en low throughout -> wr_en stays 0, no status pulses. Raise capture_en mid-frame -> no writes until after the next vs_rise.
- reset asserted at line 200 for 1 cycle -> all outputs 0 next cycle, no status pulse for that frame. Capture resumes only after capture_en=1 and a fresh vs_rise.
- vs rising in the same cycle as de=1 -> that pixel is not written, frame_err pulse, locked=0.
